// File: rtl/bnn_sequencer.sv
// bnn_sequencer: top-level control FSM for the MNIST BNN datapath.
// Collects a 28x28 binary image from a byte stream into the 784-bit pixel
// bus. It then walks the shared layer state bus through the three layers,
// supervising each layer with a timeout and counting compute cycles.
// N_PIXELS must be an exact multiple of BYTE_W.
module bnn_sequencer #(
   parameter int N_PIXELS = 784,
   parameter int BYTE_W   = 8,
   parameter int TIMEOUT  = 4096,
   parameter int CYC_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [BYTE_W-1:0]   pix_in,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic [N_PIXELS-1:0] pixels,
   output logic [2:0]          state,
   input  logic                l1_done,
   input  logic                l2_done,
   input  logic                l3_done,
   output logic                busy,
   output logic                result_valid,
   output logic                error,
   output logic [CYC_W-1:0]    cycles
);

   localparam int N_BYTES = N_PIXELS / BYTE_W;
   localparam int CNT_W   = $clog2(N_BYTES + 1);
   localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(N_BYTES);
   localparam logic [TMR_W-1:0] LP_TMR_LAST = TMR_W'(TIMEOUT - 1);

   // Codes are decoded directly by the layer blocks, so they are fixed.
   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_LAYER_1 = 3'b010,
      S_LAYER_2 = 3'b011,
      S_LAYER_3 = 3'b100,
      S_DONE    = 3'b101
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_next;
   logic [TMR_W-1:0]    r_timer;
   logic                r_error;
   logic                r_busy;
   logic                r_result_valid;
   logic                r_pix_ready;
   logic [CYC_W-1:0]    r_cycles;
   logic [N_PIXELS-1:0] w_pixels;
   logic [N_PIXELS-1:0] w_shift_src;
   logic                w_accept;
   logic                w_timeout;
   logic                w_enter_load;
   logic                w_in_layer;
   logic                w_next_busy;
   logic                w_layer_done;
   logic                w_done_ok;
   logic                w_tmr_expired;

   // Route only the done input owned by the current layer; others are ignored.
   always_comb begin
      case (r_state)
         S_LAYER_1: w_layer_done = l1_done;
         S_LAYER_2: w_layer_done = l2_done;
         S_LAYER_3: w_layer_done = l3_done;
         default:   w_layer_done = 1'b0;
      endcase
   end

   assign w_in_layer    = (r_state == S_LAYER_1) || (r_state == S_LAYER_2) ||
                          (r_state == S_LAYER_3);
   // Timer is zero only in the entry cycle. A done still high from before
   // entry is therefore not taken as this layer's completion.
   assign w_done_ok     = w_layer_done && (r_timer != '0);
   assign w_tmr_expired = (r_timer == LP_TMR_LAST);

   // Next-state decision: abort beats timeout, timeout beats nothing over done.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_timeout    = 1'b0;
      if (abort) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
               if (r_count == LP_LAST_CNT) begin
                  w_state_next = S_LAYER_1;
               end else if (pix_valid && r_pix_ready) begin
                  w_accept = 1'b1;
               end
            end
            S_LAYER_1: begin
               if (w_done_ok) begin
                  w_state_next = S_LAYER_2;
               end else if (w_tmr_expired) begin
                  w_state_next = S_IDLE;
                  w_timeout    = 1'b1;
               end
            end
            S_LAYER_2: begin
               if (w_done_ok) begin
                  w_state_next = S_LAYER_3;
               end else if (w_tmr_expired) begin
                  w_state_next = S_IDLE;
                  w_timeout    = 1'b1;
               end
            end
            S_LAYER_3: begin
               if (w_done_ok) begin
                  w_state_next = S_DONE;
               end else if (w_tmr_expired) begin
                  w_state_next = S_IDLE;
                  w_timeout    = 1'b1;
               end
            end
            S_DONE: begin
               if (start) w_state_next = S_LOAD;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   assign w_enter_load = (w_state_next == S_LOAD) && (r_state != S_LOAD);
   assign w_next_busy  = (w_state_next == S_LOAD)    || (w_state_next == S_LAYER_1) ||
                         (w_state_next == S_LAYER_2) || (w_state_next == S_LAYER_3);

   // Byte counter restarts on a new image and on abort (a dropped byte is lost).
   always_comb begin
      w_count_next = r_count;
      if (w_enter_load || abort) begin
         w_count_next = '0;
      end else if (w_accept) begin
         w_count_next = r_count + 1'b1;
      end
   end

   // FSM register with registered status outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_count        <= '0;
         r_timer        <= '0;
         r_error        <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_pix_ready    <= 1'b0;
         r_cycles       <= '0;
      end else begin
         r_state        <= w_state_next;
         r_count        <= w_count_next;
         r_pix_ready    <= (w_state_next == S_LOAD) && (w_count_next < LP_LAST_CNT);
         r_busy         <= w_next_busy;
         r_result_valid <= (w_state_next == S_DONE);

         if (w_state_next != r_state) begin
            r_timer <= '0;
         end else if (w_in_layer) begin
            r_timer <= r_timer + 1'b1;
         end

         if (w_enter_load) begin
            r_error <= 1'b0;
         end else if (w_timeout) begin
            r_error <= 1'b1;
         end

         if (w_enter_load) begin
            r_cycles <= '0;
         end else if (w_in_layer && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 1'b1;
         end
      end
   end

   // Lane 0 takes the incoming byte; every other lane takes its lower neighbour.
   // After the last byte, the earliest byte sits in the top lane.
   assign w_shift_src = {w_pixels[N_PIXELS-BYTE_W-1:0], pix_in};

   genvar gi;
   generate
      for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
         logic [BYTE_W-1:0] r_byte;

         // Shift this byte lane by one position on each accepted input byte.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_byte <= '0;
            end else if (w_accept) begin
               r_byte <= w_shift_src[gi*BYTE_W +: BYTE_W];
            end
         end

         assign w_pixels[gi*BYTE_W +: BYTE_W] = r_byte;
      end
   endgenerate

   assign state        = r_state;
   assign pixels       = w_pixels;
   assign pix_ready    = r_pix_ready;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign error        = r_error;
   assign cycles       = r_cycles;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Testbench for bnn_sequencer: random stimulus and gaps. The stimulus pushes
// expected state transitions and results, stamped with the clock edge on
// which they must appear. A monitor compares them on every state change.
module tb_bnn_sequencer;

   localparam int NP  = 784;
   localparam int BW  = 8;
   localparam int NB  = NP / BW;
   localparam int TMO = 64;
   localparam int CW  = 16;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [BW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_ready;
   logic [NP-1:0] pixels;
   logic [2:0]    state;
   logic          l1_done;
   logic          l2_done;
   logic          l3_done;
   logic          busy;
   logic          result_valid;
   logic          error;
   logic [CW-1:0] cycles;

   bnn_sequencer #(
      .N_PIXELS (NP),
      .BYTE_W   (BW),
      .TIMEOUT  (TMO),
      .CYC_W    (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pixels       (pixels),
      .state        (state),
      .l1_done      (l1_done),
      .l2_done      (l2_done),
      .l3_done      (l3_done),
      .busy         (busy),
      .result_valid (result_valid),
      .error        (error),
      .cycles       (cycles)
   );

   typedef struct {
      logic [2:0] st;
      int         at_c;
      logic       err;
   } trans_t;

   typedef struct {
      logic [NP-1:0] pix;
      logic [CW-1:0] cyc;
   } res_t;

   trans_t        exp_q[$];
   res_t          res_q[$];
   int            checks;
   int            errors;
   int            cyc;
   int            last_acc;
   bit            mon_en;
   logic [NP-1:0] exp_pix;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges; at the negedge after edge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic chk_pix(input string name, input logic [NP-1:0] got, input logic [NP-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic push_t(input logic [2:0] st, input int at_c, input logic err, input int stop_c);
      trans_t t;
      if (stop_c < 0 || at_c <= stop_c) begin
         t.st   = st;
         t.at_c = at_c;
         t.err  = err;
         exp_q.push_back(t);
      end
   endtask

   // Called at a negedge: pulse start for one cycle; LOAD is due on the next edge.
   task automatic do_start();
      push_t(3'd1, cyc + 1, 1'b0, -1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer n bytes with random gaps. mode 0: all 0xFF, 1: 0x80 then 0x00,
   // 2: random. Returns at the negedge after the last accepted byte.
   task automatic send_bytes(input int n, input int mode);
      logic [7:0] mb [NB];
      int sent;
      int guard;
      sent  = 0;
      guard = 0;
      for (int k = 0; k < NB; k++) mb[k] = 8'h00;
      while (sent < n && guard < 5000) begin
         if ($urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            pix_in    = 8'($urandom);
         end else begin
            pix_valid = 1'b1;
            case (mode)
               0:       pix_in = 8'hFF;
               1:       pix_in = (sent == 0) ? 8'h80 : 8'h00;
               default: pix_in = 8'($urandom);
            endcase
            if (pix_ready) begin
               mb[sent] = pix_in;
               sent++;
               last_acc = cyc + 1;
            end
         end
         @(negedge clk);
         guard++;
      end
      pix_valid = 1'b0;
      if (sent < n) begin
         checks++;
         errors++;
         $display("FAIL byte_budget got %0d bytes want %0d", sent, n);
      end
      exp_pix = '0;
      for (int k = 0; k < n; k++) exp_pix[NP-1-8*k -: 8] = mb[k];
   endtask

   // Drive the layer done inputs from the cycle before LAYER_1 entry (e1-1).
   // d<0 on layer 2 means it never finishes (timeout). Entries due after
   // stop_c are not expected; the task returns at the negedge of cycle stop_c.
   task automatic run_layers(input int e1, input int d1, input int d2, input int d3,
                             input bit l1_early, input bit l3_in_l2, input int stop_c);
      int   e2;
      int   e3;
      int   e4;
      int   end_c;
      int   c;
      res_t r;
      e2 = l1_early ? e1 + 2 : e1 + d1 + 1;
      e3 = 0;
      e4 = 0;
      push_t(3'd2, e1, 1'b0, stop_c);
      push_t(3'd3, e2, 1'b0, stop_c);
      if (d2 < 0) begin
         end_c = e2 + TMO;
         push_t(3'd0, end_c, 1'b1, stop_c);
      end else begin
         e3    = e2 + d2 + 1;
         e4    = e3 + d3 + 1;
         end_c = e4;
         push_t(3'd4, e3, 1'b0, stop_c);
         push_t(3'd5, e4, 1'b0, stop_c);
         if (stop_c < 0 || e4 <= stop_c) begin
            r.pix = exp_pix;
            r.cyc = CW'(e4 - e1);
            res_q.push_back(r);
         end
      end
      if (stop_c >= 0 && stop_c < end_c) end_c = stop_c;
      while (1) begin
         c       = cyc;
         l1_done = l1_early ? (c >= e1 - 1 && c <= e1 + 1) : (c == e1 + d1);
         l2_done = (d2 >= 0) && (c == e2 + d2);
         l3_done = ((d2 >= 0) && (c == e3 + d3)) ||
                   (l3_in_l2 && (d2 >= 0) && (c >= e2) && (c < e2 + d2));
         if (c >= e1 + 1) pix_valid = 1'b0;
         if (c >= end_c) break;
         @(negedge clk);
      end
      l1_done = 1'b0;
      l2_done = 1'b0;
      l3_done = 1'b0;
   endtask

   // Offer a byte that must be refused during the last LOAD cycle and entry cycle.
   task automatic extra_byte();
      chk("ready_after_last", 64'(pix_ready), 64'd0);
      pix_valid = 1'b1;
      pix_in    = 8'h5A;
   endtask

   // Monitor: each state change must match the next expected transition.
   initial begin
      logic [2:0] prev_st;
      trans_t     t;
      res_t       r;
      prev_st = 3'd0;
      forever begin
         @(negedge clk);
         if (state !== prev_st) begin
            if (mon_en) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_transition got state %0d at cycle %0d want none", state, cyc);
               end else begin
                  t = exp_q.pop_front();
                  $display("TRANS state=%0d cycle=%0d error=%0b cycles=%0d", state, cyc, error, cycles);
                  chk("state", 64'(state), 64'(t.st));
                  chk("trans_cycle", 64'(cyc), 64'(t.at_c));
                  chk("error", 64'(error), 64'(t.err));
                  chk("busy", 64'(busy), 64'(t.st >= 3'd1 && t.st <= 3'd4));
                  chk("result_valid", 64'(result_valid), 64'(t.st == 3'd5));
                  if (t.st == 3'd5) begin
                     if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result got cycles %0d want no result", cycles);
                     end else begin
                        r = res_q.pop_front();
                        $display("RESULT cycles=%0d pixels=%h", cycles, pixels);
                        chk_pix("pixels", pixels, r.pix);
                        chk("cycles", 64'(cycles), 64'(r.cyc));
                     end
                  end
               end
            end
            prev_st = state;
         end
      end
   end

   initial begin
      int d1;
      int e1;
      int stop;
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      last_acc  = 0;
      mon_en    = 1'b0;
      exp_pix   = '0;
      rst_n     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      pix_in    = 8'h00;
      pix_valid = 1'b0;
      l1_done   = 1'b0;
      l2_done   = 1'b0;
      l3_done   = 1'b0;

      // Reset values, sampled before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_ready", 64'(pix_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rv", 64'(result_valid), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_cycles", 64'(cycles), 64'd0);
      chk_pix("rst_pixels", pixels, '0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_hold", 64'(state), 64'd0);
      end

      // Run A: all-ones image, layer waits 30/10/5 -> 48 compute cycles.
      do_start();
      send_bytes(NB, 0);
      extra_byte();
      run_layers(last_acc + 1, 30, 10, 5, 1'b0, 1'b0, -1);
      repeat (3) @(negedge clk);
      chk_pix("pixels_held", pixels, exp_pix);
      chk("done_hold", 64'(state), 64'd5);

      // Run B: ordering image; stale l1_done at entry; l3_done during LAYER_2.
      do_start();
      send_bytes(NB, 1);
      extra_byte();
      run_layers(last_acc + 1, 0, $urandom_range(1, 40), $urandom_range(1, 20),
                 1'b1, 1'b1, -1);
      chk("msb_pixel", 64'(pixels[NP-1]), 64'd1);

      // Run C: layer 2 never finishes -> timeout, sticky error, abort keeps it.
      do_start();
      send_bytes(NB, 2);
      extra_byte();
      run_layers(last_acc + 1, $urandom_range(1, 40), -1, 0, 1'b0, 1'b0, -1);
      repeat (3) @(negedge clk);
      chk("error_sticky", 64'(error), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_keeps_error", 64'(error), 64'd1);
      chk("abort_idle", 64'(state), 64'd0);

      // Run D: abort after 50 bytes drops the 51st; restart needs all 98 bytes.
      do_start();
      send_bytes(50, 2);
      chk("ready_mid_load", 64'(pix_ready), 64'd1);
      push_t(3'd0, cyc + 1, 1'b0, -1);
      abort     = 1'b1;
      pix_valid = 1'b1;
      pix_in    = 8'($urandom);
      @(negedge clk);
      abort     = 1'b0;
      pix_valid = 1'b0;
      do_start();
      send_bytes(NB, 2);
      extra_byte();
      run_layers(last_acc + 1, $urandom_range(1, 40), $urandom_range(1, 40),
                 $urandom_range(1, 20), 1'b0, 1'b1, -1);

      // Run E: asynchronous reset in the middle of LAYER_2.
      do_start();
      send_bytes(NB, 2);
      extra_byte();
      d1   = $urandom_range(1, 40);
      e1   = last_acc + 1;
      stop = e1 + d1 + 1 + 5;
      run_layers(e1, d1, 20, 5, 1'b0, 1'b0, stop);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_state", 64'(state), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_error", 64'(error), 64'd0);
      chk("mid_rst_cycles", 64'(cycles), 64'd0);
      chk("mid_rst_ready", 64'(pix_ready), 64'd0);
      chk_pix("mid_rst_pixels", pixels, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", 64'(state), 64'd0);
      end

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("res_q_drained", 64'(res_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
